// File: rtl/mdio_pkg.sv
// Shared constants, FSM state type and frame builder for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;
  localparam int         HDR_BITS   = 14;
  localparam int         DATA_BITS  = 16;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_t;

  // Post-preamble frame; read TA/data are ones so mdd_o idles high while released.
  function automatic logic [31:0] mdio_frame(input logic       wr,
                                             input logic [4:0] phy,
                                             input logic [4:0] regad,
                                             input logic [15:0] wdata);
    if (wr) return {MDIO_ST, MDIO_OP_WR, phy, regad, MDIO_TA_WR, wdata};
    return {MDIO_ST, MDIO_OP_RD, phy, regad, 2'b11, 16'hFFFF};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV high; held low and phase-reset while disabled.
// fall_stb marks the cycle before MDC falls, sample_stb the last low-phase cycle.
module mdio_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic sample_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          half_end;

  assign half_end   = (cnt == CW'(CLK_DIV - 1));
  assign fall_stb   = en && mdc && half_end;
  assign sample_stb = en && !mdc && half_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master; rsp_valid 2*CLK_DIV*(N+1) cycles after accept, req_ready only in IDLE.
// Optional MDIO_PRE_SUPPRESS_EN adds cfg_pre_suppress to skip the preamble (N=32).
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        cfg_pre_suppress,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdio_mdc,
  output logic        mdio_mdd_o,
  output logic        mdio_mdd_oe,
  input  logic        mdio_mdd_i
);

  mdio_state_t state, state_nxt;
  logic [4:0]  bitcnt, bitcnt_nxt;
  logic [31:0] tx_sr, tx_src;
  logic [15:0] rx_sr, rdata_q;
  logic        is_write, wr_src, ta_err, err_q;
  logic        fall_stb, sample_stb, accept, step, pre_sup;

`ifdef MDIO_PRE_SUPPRESS_EN
  assign pre_sup = cfg_pre_suppress;
`else
  assign pre_sup = 1'b0;
`endif

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .CLK        (CLK),
    .RST        (RST),
    .en         (state != IDLE),
    .mdc        (mdio_mdc),
    .fall_stb   (fall_stb),
    .sample_stb (sample_stb)
  );

  assign accept = req_valid && (state == IDLE);
  assign step   = accept || ((state != IDLE) && fall_stb);
  assign tx_src = accept ? mdio_frame(req_write, req_phy, req_reg, req_wdata) : tx_sr;
  assign wr_src = accept ? req_write : is_write;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      bitcnt <= 5'd0;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    req_ready  = (state == IDLE);
    rsp_valid  = (state == DONE) && fall_stb;
    rsp_rdata  = rsp_valid ? (is_write ? 16'h0000 : rx_sr) : rdata_q;
    rsp_err    = rsp_valid ? (!is_write && ta_err) : err_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt  = pre_sup ? HDR : PRE;
          bitcnt_nxt = pre_sup ? 5'(HDR_BITS - 1) : 5'(PRE_LEN - 1);
        end
      end
      default: begin
        if (fall_stb) begin
          if (bitcnt != 5'd0) begin
            bitcnt_nxt = bitcnt - 5'd1;
          end else begin
            case (state)
              PRE:     begin state_nxt = HDR;  bitcnt_nxt = 5'(HDR_BITS - 1);  end
              HDR:     begin state_nxt = TA;   bitcnt_nxt = 5'd1;              end
              TA:      begin state_nxt = DATA; bitcnt_nxt = 5'(DATA_BITS - 1); end
              DATA:    begin state_nxt = DONE; bitcnt_nxt = 5'd0;              end
              default: begin state_nxt = IDLE; bitcnt_nxt = 5'd0;              end
            endcase
          end
        end
      end
    endcase
  end

  // New bit launched on the accept edge and on every MDC falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      is_write    <= 1'b0;
      ta_err      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mdio_mdd_o  <= 1'b1;
      mdio_mdd_oe <= 1'b0;
    end else begin
      if (accept) begin
        is_write <= req_write;
        tx_sr    <= tx_src;
        ta_err   <= 1'b0;
      end
      if (step) begin
        case (state_nxt)
          PRE: begin
            mdio_mdd_o  <= 1'b1;
            mdio_mdd_oe <= 1'b1;
          end
          HDR, TA, DATA: begin
            mdio_mdd_o  <= tx_src[31];
            mdio_mdd_oe <= wr_src || (state_nxt == HDR);
            tx_sr       <= {tx_src[30:0], 1'b0};
          end
          default: begin
            mdio_mdd_o  <= 1'b1;
            mdio_mdd_oe <= 1'b0;
          end
        endcase
      end
      if (sample_stb && !is_write) begin
        if (state == TA && bitcnt == 5'd0) ta_err <= mdio_mdd_i;
        if (state == DATA) rx_sr <= {rx_sr[14:0], mdio_mdd_i};
      end
      if (rsp_valid) begin
        rdata_q <= rsp_rdata;
        err_q   <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: directed table, random reads/writes vs a field-level model,
// mid-frame reset, CLK_DIV=2 latency/back-to-back, and optional preamble suppression.
module tb_mdio_master;

  localparam int CD  = 25;
  localparam int PRE = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [4:0]  req_phy = '0, req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mdio_mdc, mdio_mdd_o, mdio_mdd_oe;
  logic [15:0] rsp_rdata;
  logic        mdio_mdd_i = 1'b1;
`ifdef MDIO_PRE_SUPPRESS_EN
  logic        cfg_pre_suppress = 1'b0;
`endif

  logic        b_req_valid = 1'b0, b_req_write = 1'b1;
  logic [4:0]  b_req_phy = 5'd1, b_req_reg = 5'd2;
  logic [15:0] b_req_wdata = 16'h0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mdc, b_mdd_o, b_mdd_oe;
  logic [15:0] b_rsp_rdata;
  logic        b_mdd_i = 1'b1;

  always #5 CLK = ~CLK;

  mdio_master dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
    .cfg_pre_suppress(cfg_pre_suppress),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mdio_mdc(mdio_mdc), .mdio_mdd_o(mdio_mdd_o), .mdio_mdd_oe(mdio_mdd_oe), .mdio_mdd_i(mdio_mdd_i)
  );

  mdio_master #(.CLK_DIV(2)) dut2 (
    .CLK(CLK), .RST(RST), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_phy(b_req_phy), .req_reg(b_req_reg), .req_wdata(b_req_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
    .cfg_pre_suppress(1'b0),
`endif
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mdio_mdc(b_mdc), .mdio_mdd_o(b_mdd_o), .mdio_mdd_oe(b_mdd_oe), .mdio_mdd_i(b_mdd_i)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t_acc = 0, hi_cnt = 0, rsp_cnt = 0, mdc_bits = 0, pre_len_cur = PRE;
  bit rd_active = 1'b0, phy_on = 1'b0;
  logic [15:0] phy_data = '0;
  bit cap_o[$], cap_oe[$], exp_o[$], exp_oe[$];
  logic [13:0] last_hdr;
  logic [31:0] last_w32;

  typedef struct {
    bit wr; logic [4:0] phy; logic [4:0] rg; logic [15:0] wd;
    bit pon; logic [15:0] pdata;
    logic [13:0] exp_hdr; logic [31:0] exp_w32; logic [15:0] exp_rd; bit exp_err;
  } vec_t;
  vec_t tbl[5];

  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (mdio_mdc) hi_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  // PHY: bit j is what the master sees in MDC period j; PHY updates after each rising edge.
  function automatic bit phy_bit(input int j);
    int b;
    b = pre_len_cur;
    if (!rd_active || !phy_on) return 1'b1;
    if (j == b + 15) return 1'b0;
    if (j >= b + 16 && j < b + 32) return phy_data[15 - (j - b - 16)];
    return 1'b1;
  endfunction

  always @(posedge mdio_mdc) begin
    cap_o.push_back(mdio_mdd_o);
    cap_oe.push_back(mdio_mdd_oe);
    mdc_bits++;
    mdio_mdd_i = phy_bit(mdc_bits);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n, input bit oe);
    for (int i = n - 1; i >= 0; i--) begin
      exp_o.push_back(v[i]);
      exp_oe.push_back(oe);
    end
  endtask

  task automatic send(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                      input logic [15:0] wd, input bit pon, input logic [15:0] pdata, input bit psup);
    @(negedge CLK);
    rd_active = !wr; phy_on = pon; phy_data = pdata; pre_len_cur = psup ? 0 : PRE;
    cap_o.delete(); cap_oe.delete(); mdc_bits = 0; hi_cnt = 0; mdio_mdd_i = 1'b1;
    req_write = wr; req_phy = phy; req_reg = rg; req_wdata = wd;
`ifdef MDIO_PRE_SUPPRESS_EN
    cfg_pre_suppress = psup;
`endif
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    t_acc = cyc;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input bit pon, input logic [15:0] pdata,
                         input bit psup, input logic [15:0] exp_rd, input bit exp_err);
    int n_bits, bad;
    bit got;
    n_bits = (psup ? 0 : PRE) + 32;
    send(wr, phy, rg, wd, pon, pdata, psup);
    got = 1'b0;
    for (int k = 0; k < 2 * CD * (n_bits + 1) + 100; k++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    chk("rsp_seen", got, 1);
    chk("latency", cyc - t_acc, 2 * CD * (n_bits + 1));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    @(negedge CLK);
    chk("rsp_pulse_one_cycle", rsp_valid, 0);
    chk("rdata_held", rsp_rdata, exp_rd);
    chk("mdc_high_cycles", hi_cnt, CD * (n_bits + 1));
    chk("mdc_idle_low", mdio_mdc, 0);
    exp_o.delete(); exp_oe.delete();
    if (!psup) push_bits(32'hFFFF_FFFF, PRE, 1'b1);
    push_bits(32'b01, 2, 1'b1);
    push_bits(wr ? 32'b01 : 32'b10, 2, 1'b1);
    push_bits({27'd0, phy}, 5, 1'b1);
    push_bits({27'd0, rg}, 5, 1'b1);
    if (wr) begin
      push_bits(32'b10, 2, 1'b1);
      push_bits({16'd0, wd}, 16, 1'b1);
    end else begin
      push_bits(32'd0, 18, 1'b0);
    end
    push_bits(32'd1, 1, 1'b0);
    chk("frame_len", cap_o.size(), exp_o.size());
    bad = 0;
    for (int i = 0; i < exp_o.size() && i < cap_o.size(); i++)
      if (cap_oe[i] !== exp_oe[i] || (exp_oe[i] && cap_o[i] !== exp_o[i])) bad++;
    chk("frame_bits", bad, 0);
    last_hdr = '0; last_w32 = '0;
    for (int i = 0; i < 32; i++)
      if (pre_len_cur + i < cap_o.size()) last_w32[31 - i] = cap_o[pre_len_cur + i];
    last_hdr = last_w32[31:18];
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, t0, t1, busy_rdy;
    bit got, wr, pon;
    logic [4:0] phy, rg;
    logic [15:0] wd, pd;

    tbl[0] = '{1'b1, 5'd7,  5'd0,  16'h1140, 1'b0, 16'h0000, 14'h14E0, 32'h5382_1140, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd7,  5'd1,  16'h0000, 1'b1, 16'h796D, 14'h18E1, 32'h0,         16'h796D, 1'b0};
    tbl[2] = '{1'b0, 5'd7,  5'd1,  16'h0000, 1'b0, 16'h0000, 14'h18E1, 32'h0,         16'hFFFF, 1'b1};
    tbl[3] = '{1'b1, 5'd31, 5'd31, 16'hFFFF, 1'b0, 16'h0000, 14'h17FF, 32'h5FFE_FFFF, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 5'd0,  5'd18, 16'h0000, 1'b1, 16'h0000, 14'h1812, 32'h0,         16'h0000, 1'b0};

    repeat (3) @(negedge CLK);
    chk("rst_mdc", mdio_mdc, 0);
    chk("rst_mdd_o", mdio_mdd_o, 1);
    chk("rst_mdd_oe", mdio_mdd_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].wr, tbl[i].phy, tbl[i].rg, tbl[i].wd, tbl[i].pon, tbl[i].pdata, 1'b0,
              tbl[i].exp_rd, tbl[i].exp_err);
      chk($sformatf("tbl%0d_hdr", i), last_hdr, tbl[i].exp_hdr);
      if (tbl[i].wr) chk($sformatf("tbl%0d_w32", i), last_w32, tbl[i].exp_w32);
    end

    for (int i = 0; i < 5; i++) begin
      wr = $urandom_range(0, 1); pon = $urandom_range(0, 1);
      phy = 5'($urandom); rg = 5'($urandom); wd = 16'($urandom); pd = 16'($urandom);
      run_txn(wr, phy, rg, wd, pon, pd, 1'b0, wr ? 16'h0 : (pon ? pd : 16'hFFFF), !wr && !pon);
    end

    // Reset during bit 40 of a write: outputs snap back, frame dropped.
    send(1'b1, 5'd3, 5'd4, 16'hA5A5, 1'b0, 16'h0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 2 * CD * 50; k++) begin
      if (mdc_bits >= 40) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    chk("reach_bit40", got, 1);
    r0 = rsp_cnt;
    RST = 1'b1;
    #1;
    chk("midrst_mdc", mdio_mdc, 0);
    chk("midrst_oe", mdio_mdd_oe, 0);
    chk("midrst_mdd_o", mdio_mdd_o, 1);
    chk("midrst_ready", req_ready, 1);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (8 * CD) @(negedge CLK);
    chk("midrst_no_rsp", rsp_cnt - r0, 0);
    chk("midrst_mdc_idle", mdio_mdc, 0);
    run_txn(1'b1, 5'd7, 5'd0, 16'h1140, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

    // CLK_DIV=2: latency and a held second request.
    @(negedge CLK);
    b_req_wdata = 16'h1234; b_req_valid = 1'b1;
    chk("b_ready_idle", b_req_ready, 1);
    t0 = cyc;
    @(negedge CLK);
    b_req_wdata = 16'h5678;
    got = 1'b0; busy_rdy = 0;
    for (int k = 0; k < 1000; k++) begin
      if (b_rsp_valid) begin got = 1'b1; break; end
      if (b_req_ready) busy_rdy++;
      @(negedge CLK);
    end
    chk("b_rsp_seen", got, 1);
    chk("b_latency", cyc - t0, 260);
    chk("b_busy_not_ready", busy_rdy, 0);
    @(negedge CLK);
    chk("b_second_accept_cycle", b_req_ready, 1);
    t1 = cyc;
    @(negedge CLK);
    b_req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (b_rsp_valid) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    chk("b2_rsp_seen", got, 1);
    chk("b2_latency", cyc - t1, 260);
    chk("b2_rdata_write", b_rsp_rdata, 0);

`ifdef MDIO_PRE_SUPPRESS_EN
    run_txn(1'b1, 5'd7, 5'd0, 16'h1140, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("nopre_first_bits", last_hdr[13:12], 2'b01);
    run_txn(1'b0, 5'd7, 5'd1, 16'h0, 1'b1, 16'h796D, 1'b1, 16'h796D, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
